vga_frame_monitor: RTL and testbench
====================================

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 SHALL have port clk24  input  1  system clock, all logic on its rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port ce12  input  1  sample enable; inputs are evaluated only on clk24 edges where ce12=1 ("samples").
REQ-004 SHALL have port hsync  input  1  VGA hsync, active-low, synchronous to clk24.
REQ-005 SHALL have port vsync  input  1  VGA vsync, active-low, synchronous to clk24.
REQ-006 SHALL have port realcolor  input  8  pixel value as driven to the VGA DAC.
REQ-007 SHALL have port clr_err  input  1  clears the sticky error flag.
REQ-008 SHALL have port line_len  output  11  samples in the last complete hsync period.
REQ-009 SHALL have port frame_lines  output  10  hsync periods in the last complete frame.
REQ-010 SHALL have port frame_crc  output  16  CRC of the last complete frame.
REQ-011 SHALL have port frame_done  output  1  one-clk24 pulse when line/frame results update at frame end.
REQ-012 SHALL have port locked  output  1  geometry stable across consecutive frames.
REQ-013 SHALL have port err  output  1  sticky geometry-loss flag.

Function
REQ-014 SHALL register hsync/vsync on each sample; falling edge = previous sample 1, current sample 0.
REQ-015 SHALL keep hcnt (11 bits); on hsync falling edge: line_len <= hcnt+1, hcnt <= 0; otherwise hcnt increments, saturating at 2047.
REQ-016 SHALL keep vcnt (10 bits), incremented on each hsync falling edge, saturating at 1023.
REQ-017 SHALL, on vsync falling edge, load frame_lines <= vcnt (including any hsync edge on the same sample) and clear vcnt to 0.
REQ-018 SHALL accumulate CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR) over realcolor on every sample with hsync=1 and vsync=1.
REQ-019 SHALL, on vsync falling edge, load frame_crc with the accumulator (the edge sample itself excluded) and reinitialise it to 0xFFFF.
REQ-020 SHALL assert frame_done for exactly one clk24 cycle, the cycle after the vsync-edge sample, when frame_lines/frame_crc are already valid.
REQ-021 SHALL implement FSM SEARCH -> MEASURE -> LOCKED; locked=1 only in LOCKED.
REQ-022 SEARCH: on first vsync falling edge go to MEASURE; the partial frame results are still published.
REQ-023 MEASURE: at a vsync edge, if frame_lines and line_len equal those of the previous frame end and neither counter saturated, go to LOCKED; otherwise stay.
REQ-024 LOCKED: a mismatch at a frame end, or any hsync edge whose hcnt+1 differs from line_len, SHALL go to MEASURE and set err.
REQ-025 SHALL hold err until a cycle with clr_err=1; if clr_err and a new error coincide, err stays 1.
REQ-026 SHALL ignore hsync/vsync and realcolor on cycles with ce12=0.

Reset
REQ-027 SHALL, while reset_n=0, force line_len=0, frame_lines=0, frame_crc=0x0000, frame_done=0, locked=0, err=0, hcnt=vcnt=0, CRC accumulator 0xFFFF, sync registers 1, FSM=SEARCH.
REQ-028 SHALL resume from SEARCH after reset deassertion regardless of mid-line/mid-frame position; no result published until the next vsync edge.

Verification
REQ-029 Steady timing: ce12 every 2nd clk24, 768 samples/line, 312 lines/frame -> after 3rd vsync edge line_len=768, frame_lines=312, locked=1, err=0.
REQ-030 CRC: realcolor constant 0x00 over 2 visible samples then vsync edge -> frame_crc equals CCITT of {0x00,0x00} from 0xFFFF (0x1D0F); constant data over identical frames yields identical frame_crc each frame.
REQ-031 Loss of lock: locked stream, one line shortened to 767 -> locked=0, err=1 next cycle; clr_err pulse -> err=0; relock two frames later.
REQ-032 Coincident edges: hsync and vsync fall on same sample -> that line counted in frame_lines; frame_done exactly one cycle.
REQ-033 Saturation: hsync held high 3000 samples -> hcnt stops at 2047, next edge line_len=2047, FSM not LOCKED.
REQ-034 Reset mid-frame: reset_n pulsed low while LOCKED -> all outputs at REQ-027 values; relock after 2 further complete frames.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// Passive monitor for a VGA timing stream. Inputs are only looked at on clk24
// edges where ce12=1 ("samples"). For each frame it measures the line length
// (samples per hsync period) and the number of lines, and it computes a
// CRC-16-CCITT over the visible pixels. A small FSM declares the geometry
// locked once two consecutive frames agree. A sticky error flag records any
// loss of lock.
//
// Ports
//   clk24       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   ce12        in   sample enable
//   hsync       in   active-low horizontal sync
//   vsync       in   active-low vertical sync
//   realcolor   in   [7:0] pixel value, CRC input
//   clr_err     in   clears the sticky error flag
//   line_len    out  [10:0] samples in the last complete hsync period
//   frame_lines out  [9:0] hsync periods in the last complete frame
//   frame_crc   out  [15:0] CRC of the last complete frame
//   frame_done  out  one-cycle pulse after the frame-end sample
//   locked      out  geometry stable across consecutive frames
//   err         out  sticky geometry-loss flag
module vga_frame_monitor (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic        ce12,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  realcolor,
  input  logic        clr_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [15:0] frame_crc,
  output logic        frame_done,
  output logic        locked,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // One byte of CRC-16-CCITT (poly 0x1021), MSB first, no reflection.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc_in,
                                                   input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic        hs_q;
  logic        vs_q;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [15:0] crc_acc;
  logic [9:0]  prev_lines;
  logic [10:0] prev_len;
  logic        prev_valid;
  state_t      state;
  state_t      state_next;
  logic        err_set;

  logic        hs_fall;
  logic        vs_fall;
  logic [10:0] hcnt_inc;
  logic [9:0]  vcnt_inc;
  logic [9:0]  lines_at_edge;
  logic [10:0] len_at_edge;
  logic        geom_match;
  logic        geom_sat;
  logic        hline_bad;

  // Edge detection and the values a frame end would publish on this sample.
  // hcnt_inc doubles as the measured length (hcnt+1) so the 2047 clamp also
  // keeps that measurement inside 11 bits.
  always_comb begin
    hs_fall       = ce12 & hs_q & ~hsync;
    vs_fall       = ce12 & vs_q & ~vsync;
    hcnt_inc      = (hcnt == 11'd2047) ? 11'd2047 : hcnt + 11'd1;
    vcnt_inc      = (vcnt == 10'd1023) ? 10'd1023 : vcnt + 10'd1;
    lines_at_edge = hs_fall ? vcnt_inc : vcnt;
    len_at_edge   = hs_fall ? hcnt_inc : line_len;
    geom_match    = prev_valid && (lines_at_edge == prev_lines) &&
                    (len_at_edge == prev_len);
    geom_sat      = (lines_at_edge == 10'd1023) || (len_at_edge == 11'd2047);
    hline_bad     = hs_fall && (hcnt_inc != line_len);
  end

  // Sync input registers, updated only on samples.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else if (ce12) begin
      hs_q <= hsync;
      vs_q <= vsync;
    end
  end

  // Horizontal and vertical counters plus the line length result.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      hcnt     <= 11'd0;
      vcnt     <= 10'd0;
      line_len <= 11'd0;
    end else if (ce12) begin
      if (hs_fall) begin
        line_len <= hcnt_inc;
        hcnt     <= 11'd0;
      end else begin
        hcnt     <= hcnt_inc;
      end
      // A coincident hsync edge belongs to the frame that is ending.
      if (vs_fall) begin
        vcnt <= 10'd0;
      end else if (hs_fall) begin
        vcnt <= vcnt_inc;
      end
    end
  end

  // Frame results and CRC accumulation over visible samples.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      frame_lines <= 10'd0;
      frame_crc   <= 16'h0000;
      frame_done  <= 1'b0;
      crc_acc     <= 16'hFFFF;
    end else begin
      frame_done <= vs_fall;
      if (vs_fall) begin
        frame_lines <= lines_at_edge;
        frame_crc   <= crc_acc;
        crc_acc     <= 16'hFFFF;
      end else if (ce12 && hsync && vsync) begin
        crc_acc <= crc16_ccitt_byte(crc_acc, realcolor);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic and error detection.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_next = ST_MEASURE;
        end else begin
          state_next = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (vs_fall && geom_match && !geom_sat) begin
          state_next = ST_LOCKED;
        end else begin
          state_next = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (hline_bad || (vs_fall && !geom_match)) begin
          state_next = ST_MEASURE;
          err_set    = 1'b1;
        end else begin
          state_next = ST_LOCKED;
        end
      end
      default: begin
        state_next = ST_SEARCH;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // Reference geometry from the previous frame end. The first edge after
  // SEARCH closes a partial frame, and a mid-frame loss of lock leaves a
  // frame that cannot be trusted, so neither counts as a reference.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      prev_lines <= 10'd0;
      prev_len   <= 11'd0;
      prev_valid <= 1'b0;
    end else if (vs_fall) begin
      prev_lines <= lines_at_edge;
      prev_len   <= len_at_edge;
      prev_valid <= (state != ST_SEARCH);
    end else if (hline_bad && (state == ST_LOCKED)) begin
      prev_valid <= 1'b0;
    end
  end

  // Sticky error flag; a new error wins over a coincident clear.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
module tb_vga_frame_monitor;

  logic        clk24 = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce12 = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [7:0]  realcolor = 8'h00;
  logic        clr_err = 1'b0;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [15:0] frame_crc;
  logic        frame_done;
  logic        locked;
  logic        err;

  vga_frame_monitor dut (
    .clk24(clk24), .reset_n(reset_n), .ce12(ce12), .hsync(hsync),
    .vsync(vsync), .realcolor(realcolor), .clr_err(clr_err),
    .line_len(line_len), .frame_lines(frame_lines), .frame_crc(frame_crc),
    .frame_done(frame_done), .locked(locked), .err(err)
  );

  always #5 clk24 = ~clk24;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          len;
    int          lines;
    logic [15:0] crc;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state (sample-level, unbounded counters clamped on report)
  int         m_since, m_lines, m_state, m_ref_len, m_ref_lines, m_line_len;
  int         m_frames;
  bit         m_ref_valid, m_err, m_prev_hs, m_prev_vs;
  logic [7:0] m_bytes[$];
  bit         clr_next = 1'b0;
  bit         mon_en = 1'b0;
  bit         fd_prev = 1'b0;
  int         frames_seen = 0;
  exp_t       mon_e;

  task automatic check(string name, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (m_bytes[k]) begin
      c = c ^ {m_bytes[k], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic model_reset();
    m_since = 0; m_lines = 0; m_state = 0; m_ref_len = 0; m_ref_lines = 0;
    m_line_len = 0; m_ref_valid = 1'b0; m_err = 1'b0;
    m_prev_hs = 1'b1; m_prev_vs = 1'b1;
    m_bytes.delete();
  endtask

  // States: 0 = searching, 1 = measuring, 2 = locked.
  task automatic model_step(bit hs, bit vs, logic [7:0] col, bit clr);
    bit hf, vf, loss, match, sat;
    int fl, st0;
    exp_t e;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    loss = 1'b0;
    m_since++;
    if (hs && vs) m_bytes.push_back(col);
    if (hf) begin
      fl = (m_since > 2047) ? 2047 : m_since;
      if (m_state == 2 && fl != m_line_len) begin
        m_state = 1; m_ref_valid = 1'b0; loss = 1'b1;
      end
      m_line_len = fl;
      m_since = 0;
      m_lines++;
    end
    if (vf) begin
      fl = (m_lines > 1023) ? 1023 : m_lines;
      e.len = m_line_len; e.lines = fl; e.crc = crc_model();
      sb_q.push_back(e);
      m_frames++;
      match = m_ref_valid && fl == m_ref_lines && m_line_len == m_ref_len;
      sat = (fl == 1023) || (m_line_len == 2047);
      st0 = m_state;
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (match && !sat) m_state = 2;
      end else if (!match) begin
        m_state = 1; loss = 1'b1;
      end
      m_ref_valid = (st0 != 0);
      m_ref_len = m_line_len;
      m_ref_lines = fl;
      m_lines = 0;
      m_bytes.delete();
    end
    if (loss) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_prev_hs = hs; m_prev_vs = vs;
  endtask

  // One sample: ce12=1 cycle with real inputs, then ce12=0 cycle with junk.
  task automatic sample(bit hs, bit vs, logic [7:0] col);
    bit clr;
    clr = clr_next;
    clr_next = 1'b0;
    ce12 = 1'b1; hsync = hs; vsync = vs; realcolor = col; clr_err = clr;
    model_step(hs, vs, col, clr);
    @(posedge clk24);
    @(negedge clk24);
    check("locked", locked, (m_state == 2));
    check("err", err, m_err);
    ce12 = 1'b0; clr_err = 1'b0;
    hsync = 1'($urandom); vsync = 1'($urandom); realcolor = 8'($urandom);
    @(posedge clk24);
    #1;
  endtask

  task automatic run_frame(int nl, int len, int short_idx, int start_l,
                           int stop_l, bit cmode, logic [7:0] cval);
    for (int l = start_l; l < stop_l; l++) begin
      int ll;
      ll = (l == short_idx) ? len - 1 : len;
      for (int s = 0; s < ll; s++) begin
        sample((s < 8) ? 1'b0 : 1'b1, (l < 2) ? 1'b0 : 1'b1,
               cmode ? cval : 8'($urandom));
      end
    end
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_frame_crc"}, frame_crc, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Scoreboard monitor: compares published results whenever frame_done fires.
  always @(negedge clk24) begin
    if (mon_en) begin
      if (fd_prev) check("frame_done_width", frame_done, 0);
      if (frame_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("frame_line_len", line_len, mon_e.len);
          check("frame_lines", frame_lines, mon_e.lines);
          check("frame_crc", frame_crc, mon_e.crc);
          frames_seen++;
        end
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    int nl, len;
    m_frames = 0;
    model_reset();
    nl  = $urandom_range(8, 12);
    len = $urandom_range(24, 40);
    repeat (2) @(posedge clk24);
    @(negedge clk24);
    check_reset_values("reset");
    @(posedge clk24);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Steady stream starting mid-frame; lock after the third frame end.
    run_frame(nl, len, -1, 3, nl, 1'b0, 8'h00);
    repeat (4) run_frame(nl, len, -1, 0, nl, 1'b0, 8'h00);
    check("steady_line_len", line_len, len);
    check("steady_frame_lines", frame_lines, nl);
    check("steady_locked", locked, 1);

    // Loss of lock from one shortened line, then clear and relock.
    run_frame(nl, len, 5, 0, nl, 1'b0, 8'h00);
    check("loss_err", err, 1);
    clr_next = 1'b1;
    repeat (3) run_frame(nl, len, -1, 0, nl, 1'b0, 8'h00);
    check("relock_err", err, 0);
    check("relock_locked", locked, 1);

    // Frame with exactly two visible 0x00 samples; clear coincides with error.
    sample(1'b0, 1'b0, 8'h11);
    repeat (3) sample(1'b0, 1'b0, 8'h22);
    repeat (3) sample(1'b0, 1'b1, 8'h33);
    repeat (2) sample(1'b1, 1'b1, 8'h00);
    clr_next = 1'b1;
    sample(1'b1, 1'b0, 8'h44);
    check("crc_two_zero", frame_crc, 16'h1D0F);
    check("crc_frame_lines", frame_lines, 0);
    check("err_clr_coincident", err, 1);
    clr_next = 1'b1;
    sample(1'b1, 1'b0, 8'h55);
    check("err_cleared", err, 0);

    // Constant pixel data over several frames.
    repeat (3) run_frame(nl, len, -1, 0, nl, 1'b1, 8'h5A);

    // hcnt saturation: long hsync-high runs ending in coincident edges.
    repeat (2) begin
      repeat (3000) sample(1'b1, 1'b1, 8'($urandom));
      sample(1'b0, 1'b0, 8'h00);
      check("sat_line_len", line_len, 2047);
    end
    check("sat_not_locked", locked, 0);

    // Reset in the middle of a locked frame, then relock.
    clr_next = 1'b1;
    repeat (4) run_frame(nl, len, -1, 0, nl, 1'b0, 8'h00);
    check("prereset_locked", locked, 1);
    run_frame(nl, len, -1, 0, 4, 1'b0, 8'h00);
    ce12 = 1'b0;
    reset_n = 1'b0;
    @(negedge clk24);
    check_reset_values("midreset");
    @(posedge clk24);
    #1;
    reset_n = 1'b1;
    model_reset();
    sb_q.delete();
    run_frame(nl, len, -1, 4, nl, 1'b0, 8'h00);
    repeat (3) run_frame(nl, len, -1, 0, nl, 1'b0, 8'h00);
    check("postreset_locked", locked, 1);
    check("postreset_line_len", line_len, len);

    repeat (4) @(posedge clk24);
    check("scoreboard_empty", sb_q.size(), 0);
    check("frames_seen", frames_seen, m_frames);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
